// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RV32I execute stage:
//   - XLEN (datapath width, 32 only)
//   - ALU function codes produced by the ID-stage ALU-control decode
//   - operand-A source codes
//   - branch func3 condition codes
//   - the ID/EX pipeline register layout
//   - helpers for operand forwarding and branch evaluation
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN = 32;

    // ALU function codes; 1010..1111 are undefined and produce zero
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SRA  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Operand-A source select
    typedef enum logic [1:0] {
        ASRC_RS1  = 2'b00,
        ASRC_PC   = 2'b01,
        ASRC_ZERO = 2'b10
    } a_src_e;

    // Branch condition codes (func3 of B-type instructions)
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_func;
        logic [1:0]      a_src;
        logic            b_src_imm;
        logic [2:0]      func3;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } idex_t;

    // Branch condition evaluation; unused func3 encodings are never taken
    function automatic logic branch_taken(
        input logic [2:0]      f3,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic taken;
        taken = 1'b0;
        case (f3)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LT:   taken = ($signed(a) <  $signed(b));
            BR_GE:   taken = ($signed(a) >= $signed(b));
            BR_LTU:  taken = (a <  b);
            BR_GEU:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Operand forwarding: the younger MEM result beats WB, and x0 is
    // never forwarded because it is hard-wired to zero.
    function automatic logic [XLEN-1:0] fwd_select(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf_data,
        input logic [4:0]      mem_rd,
        input logic            mem_we,
        input logic [XLEN-1:0] mem_data,
        input logic [4:0]      wb_rd,
        input logic            wb_we,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] sel;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            sel = mem_data;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = wb_data;
        end else begin
            sel = rf_data;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational RV32I integer ALU.
// Ports:
//   a_i      [XLEN] operand A
//   b_i      [XLEN] operand B (shift amount taken from b_i[4:0])
//   func_i   [4]    ALU function code (see rv32_pkg ALU_*)
//   result_o [XLEN] result; undefined codes give zero
// -----------------------------------------------------------------------------
import rv32_pkg::*;

module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      func_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt_s;

    assign shamt_s = b_i[4:0];

    // Select the operation for the current function code
    always_comb begin
        result_o = {XLEN{1'b0}};
        case (func_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt_s;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt_s);
            ALU_SRL:  result_o = a_i >> shamt_s;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default:  result_o = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// Execute stage of the RV32I pipeline. Holds the ID/EX register, forwards
// operands from MEM and WB, evaluates ALU / branch / jump, drives the
// front-end redirect and registers the outcome into EX/MEM.
// Ports:
//   clk_I, rst_I                 clock, asynchronous active-high reset
//   stall_I                      hold both pipeline registers
//   flush_I                      load a bubble into ID/EX
//   id*_I                        decoded instruction from ID
//   memRd_I/memRegWrite_I/memFwdData_I   EX/MEM forwarding source
//   wbRd_I/wbRegWrite_I/wbFwdData_I      MEM/WB forwarding source
//   redirect_O, redirectPc_O     taken branch / jump and its target
//   exm*_O                       EX/MEM register outputs
// -----------------------------------------------------------------------------
import rv32_pkg::*;

module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_I,
    input  logic            rst_I,
    input  logic            stall_I,
    input  logic            flush_I,
    input  logic            idValid_I,
    input  logic [XLEN-1:0] idPc_I,
    input  logic [XLEN-1:0] idRs1Data_I,
    input  logic [XLEN-1:0] idRs2Data_I,
    input  logic [XLEN-1:0] idImm_I,
    input  logic [4:0]      idRs1_I,
    input  logic [4:0]      idRs2_I,
    input  logic [4:0]      idRd_I,
    input  logic [3:0]      idAluFunc_I,
    input  logic [1:0]      idASrc_I,
    input  logic            idBSrcImm_I,
    input  logic [2:0]      idFunc3_I,
    input  logic            idBranch_I,
    input  logic            idJal_I,
    input  logic            idJalr_I,
    input  logic            idRegWrite_I,
    input  logic            idMemRead_I,
    input  logic            idMemWrite_I,
    input  logic [4:0]      memRd_I,
    input  logic            memRegWrite_I,
    input  logic [XLEN-1:0] memFwdData_I,
    input  logic [4:0]      wbRd_I,
    input  logic            wbRegWrite_I,
    input  logic [XLEN-1:0] wbFwdData_I,
    output logic            redirect_O,
    output logic [XLEN-1:0] redirectPc_O,
    output logic            exmValid_O,
    output logic            exmRegWrite_O,
    output logic            exmMemRead_O,
    output logic            exmMemWrite_O,
    output logic [XLEN-1:0] exmResult_O,
    output logic [XLEN-1:0] exmStoreData_O,
    output logic [4:0]      exmRd_O,
    output logic [2:0]      exmFunc3_O
);

    // ---------------------------------------------------------------------
    // ID/EX register
    // ---------------------------------------------------------------------
    idex_t idex_q;
    idex_t idex_d;

    // ---------------------------------------------------------------------
    // EX/MEM register
    // ---------------------------------------------------------------------
    logic            exm_valid_q,      exm_valid_d;
    logic            exm_reg_write_q,  exm_reg_write_d;
    logic            exm_mem_read_q,   exm_mem_read_d;
    logic            exm_mem_write_q,  exm_mem_write_d;
    logic [XLEN-1:0] exm_result_q,     exm_result_d;
    logic [XLEN-1:0] exm_store_data_q, exm_store_data_d;
    logic [4:0]      exm_rd_q,         exm_rd_d;
    logic [2:0]      exm_func3_q,      exm_func3_d;

    // ---------------------------------------------------------------------
    // Execute datapath
    // ---------------------------------------------------------------------
    logic            ctl_branch_s;
    logic            ctl_jal_s;
    logic            ctl_jalr_s;
    logic            ctl_reg_write_s;
    logic            ctl_mem_read_s;
    logic            ctl_mem_write_s;
    logic [XLEN-1:0] fwd_rs1_s;
    logic [XLEN-1:0] fwd_rs2_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic [XLEN-1:0] alu_result_s;
    logic            cond_s;
    logic            redirect_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] redirect_pc_s;

    // Bubble gating: an invalid ID/EX entry must have no side effects
    always_comb begin
        ctl_branch_s    = idex_q.valid & idex_q.branch;
        ctl_jal_s       = idex_q.valid & idex_q.jal;
        ctl_jalr_s      = idex_q.valid & idex_q.jalr;
        ctl_reg_write_s = idex_q.valid & idex_q.reg_write;
        ctl_mem_read_s  = idex_q.valid & idex_q.mem_read;
        ctl_mem_write_s = idex_q.valid & idex_q.mem_write;
    end

    // Forwarding is evaluated every cycle, stalled or not, so a held
    // instruction always sees the freshest producer values.
    always_comb begin
        fwd_rs1_s = fwd_select(idex_q.rs1, idex_q.rs1_data,
                               memRd_I, memRegWrite_I, memFwdData_I,
                               wbRd_I, wbRegWrite_I, wbFwdData_I);
        fwd_rs2_s = fwd_select(idex_q.rs2, idex_q.rs2_data,
                               memRd_I, memRegWrite_I, memFwdData_I,
                               wbRd_I, wbRegWrite_I, wbFwdData_I);
    end

    // Operand selection for the ALU
    always_comb begin
        op_a_s = {XLEN{1'b0}};
        case (idex_q.a_src)
            ASRC_RS1:  op_a_s = fwd_rs1_s;
            ASRC_PC:   op_a_s = idex_q.pc;
            ASRC_ZERO: op_a_s = {XLEN{1'b0}};
            default:   op_a_s = {XLEN{1'b0}};
        endcase
        if (idex_q.b_src_imm) begin
            op_b_s = idex_q.imm;
        end else begin
            op_b_s = fwd_rs2_s;
        end
    end

    alu #(
        .XLEN     (XLEN)
    ) u_alu (
        .a_i      (op_a_s),
        .b_i      (op_b_s),
        .func_i   (idex_q.alu_func),
        .result_o (alu_result_s)
    );

    // Branch compare always uses the two forwarded registers, never operand B,
    // so an immediate-B encoding cannot corrupt the condition.
    always_comb begin
        cond_s     = branch_taken(idex_q.func3, fwd_rs1_s, fwd_rs2_s);
        redirect_s = ctl_jal_s | ctl_jalr_s | (ctl_branch_s & cond_s);
    end

    // Redirect target; forced to zero when no redirect is requested
    always_comb begin
        jalr_sum_s = fwd_rs1_s + idex_q.imm;
        if (!redirect_s) begin
            redirect_pc_s = {XLEN{1'b0}};
        end else if (ctl_jalr_s) begin
            redirect_pc_s = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            redirect_pc_s = idex_q.pc + idex_q.imm;
        end
    end

    assign redirect_O   = redirect_s;
    assign redirectPc_O = redirect_pc_s;

    // ID/EX next state; a redirect from EX squashes the wrong-path ID
    // instruction, and flush with redirect still yields a single bubble.
    always_comb begin
        idex_d           = '0;
        idex_d.valid     = idValid_I & ~flush_I & ~redirect_s;
        idex_d.pc        = idPc_I;
        idex_d.rs1_data  = idRs1Data_I;
        idex_d.rs2_data  = idRs2Data_I;
        idex_d.imm       = idImm_I;
        idex_d.rs1       = idRs1_I;
        idex_d.rs2       = idRs2_I;
        idex_d.rd        = idRd_I;
        idex_d.alu_func  = idAluFunc_I;
        idex_d.a_src     = idASrc_I;
        idex_d.b_src_imm = idBSrcImm_I;
        idex_d.func3     = idFunc3_I;
        idex_d.branch    = idBranch_I;
        idex_d.jal       = idJal_I;
        idex_d.jalr      = idJalr_I;
        idex_d.reg_write = idRegWrite_I;
        idex_d.mem_read  = idMemRead_I;
        idex_d.mem_write = idMemWrite_I;
    end

    // EX/MEM next state; jumps write the link address pc+4
    always_comb begin
        exm_valid_d      = idex_q.valid;
        exm_reg_write_d  = ctl_reg_write_s;
        exm_mem_read_d   = ctl_mem_read_s;
        exm_mem_write_d  = ctl_mem_write_s;
        if (ctl_jal_s || ctl_jalr_s) begin
            exm_result_d = idex_q.pc + 32'd4;
        end else begin
            exm_result_d = alu_result_s;
        end
        exm_store_data_d = fwd_rs2_s;
        exm_rd_d         = idex_q.rd;
        exm_func3_d      = idex_q.func3;
    end

    // ID/EX register; stall holds it and overrides flush and self-bubble
    always_ff @(posedge clk_I or posedge rst_I) begin
        if (rst_I) begin
            idex_q <= '0;
        end else if (!stall_I) begin
            idex_q <= idex_d;
        end else begin
            idex_q <= idex_q;
        end
    end

    // EX/MEM register; stall holds it as well
    always_ff @(posedge clk_I or posedge rst_I) begin
        if (rst_I) begin
            exm_valid_q      <= 1'b0;
            exm_reg_write_q  <= 1'b0;
            exm_mem_read_q   <= 1'b0;
            exm_mem_write_q  <= 1'b0;
            exm_result_q     <= {XLEN{1'b0}};
            exm_store_data_q <= {XLEN{1'b0}};
            exm_rd_q         <= 5'd0;
            exm_func3_q      <= 3'd0;
        end else if (!stall_I) begin
            exm_valid_q      <= exm_valid_d;
            exm_reg_write_q  <= exm_reg_write_d;
            exm_mem_read_q   <= exm_mem_read_d;
            exm_mem_write_q  <= exm_mem_write_d;
            exm_result_q     <= exm_result_d;
            exm_store_data_q <= exm_store_data_d;
            exm_rd_q         <= exm_rd_d;
            exm_func3_q      <= exm_func3_d;
        end else begin
            exm_valid_q      <= exm_valid_q;
            exm_reg_write_q  <= exm_reg_write_q;
            exm_mem_read_q   <= exm_mem_read_q;
            exm_mem_write_q  <= exm_mem_write_q;
            exm_result_q     <= exm_result_q;
            exm_store_data_q <= exm_store_data_q;
            exm_rd_q         <= exm_rd_q;
            exm_func3_q      <= exm_func3_q;
        end
    end

    assign exmValid_O     = exm_valid_q;
    assign exmRegWrite_O  = exm_reg_write_q;
    assign exmMemRead_O   = exm_mem_read_q;
    assign exmMemWrite_O  = exm_mem_write_q;
    assign exmResult_O    = exm_result_q;
    assign exmStoreData_O = exm_store_data_q;
    assign exmRd_O        = exm_rd_q;
    assign exmFunc3_O     = exm_func3_q;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
// Directed self-checking bench for ex_stage. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk_I = 1'b0;
    logic        rst_I;
    logic        stall_I, flush_I, idValid_I;
    logic [31:0] idPc_I, idRs1Data_I, idRs2Data_I, idImm_I;
    logic [4:0]  idRs1_I, idRs2_I, idRd_I;
    logic [3:0]  idAluFunc_I;
    logic [1:0]  idASrc_I;
    logic        idBSrcImm_I;
    logic [2:0]  idFunc3_I;
    logic        idBranch_I, idJal_I, idJalr_I;
    logic        idRegWrite_I, idMemRead_I, idMemWrite_I;
    logic [4:0]  memRd_I, wbRd_I;
    logic        memRegWrite_I, wbRegWrite_I;
    logic [31:0] memFwdData_I, wbFwdData_I;
    logic        redirect_O;
    logic [31:0] redirectPc_O;
    logic        exmValid_O, exmRegWrite_O, exmMemRead_O, exmMemWrite_O;
    logic [31:0] exmResult_O, exmStoreData_O;
    logic [4:0]  exmRd_O;
    logic [2:0]  exmFunc3_O;

    int tests_run    = 0;
    int tests_failed = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk_I(clk_I), .rst_I(rst_I), .stall_I(stall_I), .flush_I(flush_I),
        .idValid_I(idValid_I), .idPc_I(idPc_I), .idRs1Data_I(idRs1Data_I),
        .idRs2Data_I(idRs2Data_I), .idImm_I(idImm_I), .idRs1_I(idRs1_I),
        .idRs2_I(idRs2_I), .idRd_I(idRd_I), .idAluFunc_I(idAluFunc_I),
        .idASrc_I(idASrc_I), .idBSrcImm_I(idBSrcImm_I), .idFunc3_I(idFunc3_I),
        .idBranch_I(idBranch_I), .idJal_I(idJal_I), .idJalr_I(idJalr_I),
        .idRegWrite_I(idRegWrite_I), .idMemRead_I(idMemRead_I),
        .idMemWrite_I(idMemWrite_I), .memRd_I(memRd_I),
        .memRegWrite_I(memRegWrite_I), .memFwdData_I(memFwdData_I),
        .wbRd_I(wbRd_I), .wbRegWrite_I(wbRegWrite_I), .wbFwdData_I(wbFwdData_I),
        .redirect_O(redirect_O), .redirectPc_O(redirectPc_O),
        .exmValid_O(exmValid_O), .exmRegWrite_O(exmRegWrite_O),
        .exmMemRead_O(exmMemRead_O), .exmMemWrite_O(exmMemWrite_O),
        .exmResult_O(exmResult_O), .exmStoreData_O(exmStoreData_O),
        .exmRd_O(exmRd_O), .exmFunc3_O(exmFunc3_O)
    );

    always #5 clk_I = ~clk_I;

    task automatic tick();
        @(posedge clk_I);
        #1;
    endtask

    // ID presents no instruction
    task automatic id_bubble();
        idValid_I = 1'b0; idPc_I = 32'h0; idRs1Data_I = 32'h0; idRs2Data_I = 32'h0;
        idImm_I = 32'h0; idRs1_I = 5'd0; idRs2_I = 5'd0; idRd_I = 5'd0;
        idAluFunc_I = 4'h0; idASrc_I = 2'b00; idBSrcImm_I = 1'b0; idFunc3_I = 3'd0;
        idBranch_I = 1'b0; idJal_I = 1'b0; idJalr_I = 1'b0;
        idRegWrite_I = 1'b0; idMemRead_I = 1'b0; idMemWrite_I = 1'b0;
    endtask

    task automatic no_fwd();
        memRd_I = 5'd0; memRegWrite_I = 1'b0; memFwdData_I = 32'h0;
        wbRd_I = 5'd0; wbRegWrite_I = 1'b0; wbFwdData_I = 32'h0;
    endtask

    // Register-register / register-immediate ALU op, rs1=x1 rs2=x2 rd=x3
    task automatic set_alu(input logic [3:0] f, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] imm,
                           input logic bimm);
        id_bubble();
        idValid_I = 1'b1; idAluFunc_I = f; idRs1Data_I = r1; idRs2Data_I = r2;
        idImm_I = imm; idBSrcImm_I = bimm; idRs1_I = 5'd1; idRs2_I = 5'd2;
        idRd_I = 5'd3; idRegWrite_I = 1'b1; idPc_I = 32'h1000;
    endtask

    task automatic set_branch(input logic [2:0] f3, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] pc,
                              input logic [31:0] imm);
        id_bubble();
        idValid_I = 1'b1; idBranch_I = 1'b1; idFunc3_I = f3; idRs1Data_I = r1;
        idRs2Data_I = r2; idRs1_I = 5'd1; idRs2_I = 5'd2; idPc_I = pc;
        idImm_I = imm; idBSrcImm_I = 1'b1; idAluFunc_I = 4'b0001;
    endtask

    task automatic test_reset();
        rst_I = 1'b1; stall_I = 1'b0; flush_I = 1'b0;
        id_bubble(); no_fwd();
        repeat (2) tick();
        tests_run++;
        if ({exmValid_O, exmRegWrite_O, exmMemRead_O, exmMemWrite_O, exmResult_O,
             exmStoreData_O, exmRd_O, exmFunc3_O, redirect_O, redirectPc_O} !== 110'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got valid=%b res=%h rd=%0d redir=%b pc=%h, expected all 0",
                     exmValid_O, exmResult_O, exmRd_O, redirect_O, redirectPc_O);
        end
        #2 rst_I = 1'b0;
        tick();
    endtask

    task automatic test_alu_sweep();
        logic [31:0] exp_tab [0:10];
        exp_tab[0] = 32'h8000_0004; exp_tab[1] = 32'h7FFF_FFFC; exp_tab[2] = 32'h0;
        exp_tab[3] = 32'hF800_0000; exp_tab[4] = 32'h0800_0000; exp_tab[5] = 32'h0;
        exp_tab[6] = 32'h8000_0004; exp_tab[7] = 32'h8000_0004; exp_tab[8] = 32'h1;
        exp_tab[9] = 32'h0;         exp_tab[10] = 32'h0;
        for (int i = 0; i <= 10; i++) begin
            set_alu(4'(i), 32'h8000_0000, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0);
            tick();
            id_bubble();
            tick();
            tests_run++;
            if (exmResult_O !== exp_tab[i] || exmValid_O !== 1'b1 || exmRegWrite_O !== 1'b1) begin
                tests_failed++;
                $display("FAIL alu_sweep code=%0d: got res=%h v=%b rw=%b, expected res=%h v=1 rw=1",
                         i, exmResult_O, exmValid_O, exmRegWrite_O, exp_tab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_alu(4'b0000, 32'd10, 32'd20, 32'd0, 1'b0);
        tick();
        set_alu(4'b0001, 32'd100, 32'd0, 32'd1, 1'b1);
        idRd_I = 5'd4;
        tick();
        tests_run++;
        if (exmResult_O !== 32'd30 || exmRd_O !== 5'd3) begin
            tests_failed++;
            $display("FAIL b2b_first: got res=%h rd=%0d, expected res=0000001e rd=3", exmResult_O, exmRd_O);
        end
        id_bubble();
        tick();
        tests_run++;
        if (exmResult_O !== 32'd99 || exmRd_O !== 5'd4) begin
            tests_failed++;
            $display("FAIL b2b_second: got res=%h rd=%0d, expected res=00000063 rd=4", exmResult_O, exmRd_O);
        end
    endtask

    task automatic test_forwarding();
        // MEM beats WB
        set_alu(4'b0000, 32'h99, 32'h0, 32'h0, 1'b1);
        idRs1_I = 5'd5;
        memRd_I = 5'd5; memRegWrite_I = 1'b1; memFwdData_I = 32'h11;
        wbRd_I = 5'd5;  wbRegWrite_I = 1'b1;  wbFwdData_I = 32'h22;
        tick(); id_bubble(); tick();
        tests_run++;
        if (exmResult_O !== 32'h11) begin
            tests_failed++;
            $display("FAIL fwd_mem_priority: got %h, expected 00000011", exmResult_O);
        end
        // WB when MEM is not writing
        set_alu(4'b0000, 32'h99, 32'h0, 32'h0, 1'b1);
        idRs1_I = 5'd5; memRegWrite_I = 1'b0;
        tick(); id_bubble(); tick();
        tests_run++;
        if (exmResult_O !== 32'h22) begin
            tests_failed++;
            $display("FAIL fwd_wb: got %h, expected 00000022", exmResult_O);
        end
        // x0 is never forwarded
        set_alu(4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);
        idRs1_I = 5'd0;
        memRd_I = 5'd0; memRegWrite_I = 1'b1; wbRd_I = 5'd0; wbRegWrite_I = 1'b1;
        tick(); id_bubble(); tick();
        tests_run++;
        if (exmResult_O !== 32'h0) begin
            tests_failed++;
            $display("FAIL fwd_x0: got %h, expected 00000000", exmResult_O);
        end
        // rs2 forwarded from WB into both B and the store data
        set_alu(4'b0000, 32'h1, 32'h5, 32'h0, 1'b0);
        idRs2_I = 5'd6;
        memRd_I = 5'd7; memRegWrite_I = 1'b1; memFwdData_I = 32'h44;
        wbRd_I = 5'd6;  wbRegWrite_I = 1'b1;  wbFwdData_I = 32'h33;
        tick(); id_bubble(); tick();
        tests_run++;
        if (exmResult_O !== 32'h34 || exmStoreData_O !== 32'h33) begin
            tests_failed++;
            $display("FAIL fwd_rs2: got res=%h sd=%h, expected res=00000034 sd=00000033",
                     exmResult_O, exmStoreData_O);
        end
        no_fwd();
    endtask

    task automatic test_branch();
        // beq taken; B is the immediate but compare must use rs2
        set_branch(3'b000, 32'h55, 32'h55, 32'h100, 32'h20);
        tick();
        tests_run++;
        if (redirect_O !== 1'b1 || redirectPc_O !== 32'h120) begin
            tests_failed++;
            $display("FAIL beq_taken: got redir=%b pc=%h, expected redir=1 pc=00000120", redirect_O, redirectPc_O);
        end
        set_alu(4'b0000, 32'h1, 32'h1, 32'h0, 1'b0);   // wrong-path instruction
        tick();
        tests_run++;
        if (exmValid_O !== 1'b1 || redirect_O !== 1'b0) begin
            tests_failed++;
            $display("FAIL beq_exm: got v=%b redir=%b, expected v=1 redir=0", exmValid_O, redirect_O);
        end
        id_bubble();
        tick();
        tests_run++;
        if (exmValid_O !== 1'b0 || exmRegWrite_O !== 1'b0) begin
            tests_failed++;
            $display("FAIL beq_bubble: got v=%b rw=%b, expected v=0 rw=0", exmValid_O, exmRegWrite_O);
        end
        // bne with equal operands: not taken, target forced to 0
        set_branch(3'b001, 32'h55, 32'h55, 32'h100, 32'h20);
        tick();
        tests_run++;
        if (redirect_O !== 1'b0 || redirectPc_O !== 32'h0) begin
            tests_failed++;
            $display("FAIL bne_not_taken: got redir=%b pc=%h, expected redir=0 pc=00000000", redirect_O, redirectPc_O);
        end
        // blt signed: -1 < 1 taken
        set_branch(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'hFFFF_FFF8);
        tick();
        tests_run++;
        if (redirect_O !== 1'b1 || redirectPc_O !== 32'h2F8) begin
            tests_failed++;
            $display("FAIL blt_signed: got redir=%b pc=%h, expected redir=1 pc=000002f8", redirect_O, redirectPc_O);
        end
        // bltu: 0xFFFFFFFF < 1 unsigned is false
        set_branch(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h8);
        tick();
        tests_run++;
        if (redirect_O !== 1'b0) begin
            tests_failed++;
            $display("FAIL bltu_not_taken: got redir=%b, expected 0", redirect_O);
        end
        // undefined func3 010 never taken
        set_branch(3'b010, 32'h7, 32'h7, 32'h300, 32'h8);
        tick();
        tests_run++;
        if (redirect_O !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_func3_010: got redir=%b, expected 0", redirect_O);
        end
        id_bubble();
        tick();
    endtask

    task automatic test_jumps();
        set_alu(4'b0000, 32'h203, 32'h0, 32'h10, 1'b1);
        idJalr_I = 1'b1; idPc_I = 32'h40; idRd_I = 5'd1;
        tick();
        tests_run++;
        if (redirect_O !== 1'b1 || redirectPc_O !== 32'h212) begin
            tests_failed++;
            $display("FAIL jalr_target: got redir=%b pc=%h, expected redir=1 pc=00000212", redirect_O, redirectPc_O);
        end
        id_bubble();
        tick();
        tests_run++;
        if (exmResult_O !== 32'h44 || exmRegWrite_O !== 1'b1 || exmRd_O !== 5'd1) begin
            tests_failed++;
            $display("FAIL jalr_link: got res=%h rw=%b rd=%0d, expected res=00000044 rw=1 rd=1",
                     exmResult_O, exmRegWrite_O, exmRd_O);
        end
        // jal with a negative offset
        set_alu(4'b0000, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b1);
        idJal_I = 1'b1; idPc_I = 32'h80; idASrc_I = 2'b01;
        tick();
        tests_run++;
        if (redirect_O !== 1'b1 || redirectPc_O !== 32'h70) begin
            tests_failed++;
            $display("FAIL jal_target: got redir=%b pc=%h, expected redir=1 pc=00000070", redirect_O, redirectPc_O);
        end
        id_bubble();
        tick();
        tests_run++;
        if (exmResult_O !== 32'h84) begin
            tests_failed++;
            $display("FAIL jal_link: got %h, expected 00000084", exmResult_O);
        end
    endtask

    task automatic test_stall_redirect();
        set_alu(4'b0000, 32'd5, 32'd0, 32'd7, 1'b1);
        idRd_I = 5'd9;
        tick();
        set_branch(3'b000, 32'h9, 32'h9, 32'h200, 32'h40);
        tick();
        // ID now holds a wrong-path instruction; stall 3 cycles with flush noise
        set_alu(4'b0000, 32'h1, 32'h1, 32'h0, 1'b0);
        stall_I = 1'b1; flush_I = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (redirect_O !== 1'b1 || redirectPc_O !== 32'h240 || exmResult_O !== 32'd12 ||
                exmRd_O !== 5'd9 || exmValid_O !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold cyc=%0d: got redir=%b pc=%h res=%h rd=%0d v=%b, expected 1 00000240 0000000c 9 1",
                         c, redirect_O, redirectPc_O, exmResult_O, exmRd_O, exmValid_O);
            end
            tick();
        end
        stall_I = 1'b0; flush_I = 1'b0;
        tests_run++;
        if (redirect_O !== 1'b1 || exmResult_O !== 32'd12) begin
            tests_failed++;
            $display("FAIL stall_third: got redir=%b res=%h, expected redir=1 res=0000000c", redirect_O, exmResult_O);
        end
        tick();   // release edge: branch -> EX/MEM, ID/EX bubble
        tests_run++;
        if (redirect_O !== 1'b0 || exmValid_O !== 1'b1 || exmRegWrite_O !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: got redir=%b v=%b rw=%b, expected redir=0 v=1 rw=0",
                     redirect_O, exmValid_O, exmRegWrite_O);
        end
        set_alu(4'b0000, 32'd2, 32'd3, 32'd0, 1'b0);
        idRd_I = 5'd11;
        tick();
        tests_run++;
        if (exmValid_O !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_one_bubble: got v=%b, expected 0", exmValid_O);
        end
        id_bubble();
        tick();
        tests_run++;
        if (exmValid_O !== 1'b1 || exmResult_O !== 32'd5 || exmRd_O !== 5'd11) begin
            tests_failed++;
            $display("FAIL stall_after_bubble: got v=%b res=%h rd=%0d, expected v=1 res=00000005 rd=11",
                     exmValid_O, exmResult_O, exmRd_O);
        end
    endtask

    task automatic test_reset_midflight();
        set_alu(4'b0000, 32'h1000, 32'hAAAA, 32'h4, 1'b1);
        idRegWrite_I = 1'b0; idMemWrite_I = 1'b1; idFunc3_I = 3'b010;
        tick();
        idRs2Data_I = 32'hBBBB;
        tick();
        tests_run++;
        if (exmMemWrite_O !== 1'b1 || exmResult_O !== 32'h1004 || exmStoreData_O !== 32'hAAAA) begin
            tests_failed++;
            $display("FAIL store_before_reset: got mw=%b res=%h sd=%h, expected mw=1 res=00001004 sd=0000aaaa",
                     exmMemWrite_O, exmResult_O, exmStoreData_O);
        end
        id_bubble();
        #3 rst_I = 1'b1;
        #1;
        tests_run++;
        if ({exmValid_O, exmRegWrite_O, exmMemRead_O, exmMemWrite_O, exmResult_O,
             exmStoreData_O, exmRd_O, exmFunc3_O, redirect_O, redirectPc_O} !== 110'd0) begin
            tests_failed++;
            $display("FAIL reset_midflight: got v=%b mw=%b res=%h sd=%h redir=%b, expected all 0",
                     exmValid_O, exmMemWrite_O, exmResult_O, exmStoreData_O, redirect_O);
        end
        @(posedge clk_I);
        #2 rst_I = 1'b0;
        #4;
        tick();
        tests_run++;
        if (exmMemWrite_O !== 1'b0 || exmValid_O !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_discard: got mw=%b v=%b, expected mw=0 v=0", exmMemWrite_O, exmValid_O);
        end
    endtask

    initial begin
        test_reset();
        test_alu_sweep();
        test_back_to_back();
        test_forwarding();
        test_branch();
        test_jumps();
        test_stall_redirect();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
